// File: rtl/falling_sprite_engine.sv
// rtl/falling_sprite_engine.sv - falling sprites with explosions, hit counter and registered pixel output
// Optional macro FALL_ACCEL_EN: per-sprite velocity that grows every 8th fall step, capped at 4.
module falling_sprite_engine #(
  parameter int NUM_SPRITES    = 4,
  parameter int SPRITE_W       = 10,
  parameter int SPRITE_H       = 30,
  parameter int START_Y        = 90,
  parameter int HIT_Y          = 290,
  parameter int EXPLODE_FRAMES = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vsync,
  input  logic [9:0]               hpos,
  input  logic [9:0]               vpos,
  input  logic                     display_on,
  input  logic                     enable,
  input  logic [NUM_SPRITES*10-1:0] sprite_x,
  output logic                     pixel_on,
  output logic [2:0]               pixel_idx,
  output logic                     pixel_explode,
  output logic [7:0]               hit_count,
  output logic                     frame_tick
);

  typedef enum logic [1:0] {S_IDLE, S_FALL, S_EXPLODE} state_t;

  localparam logic [10:0] LP_START    = 11'(START_Y);
  localparam logic [10:0] LP_HIT      = 11'(HIT_Y);
  localparam logic [7:0]  LP_CNT_INIT = 8'(EXPLODE_FRAMES - 1);

  logic r_vs_meta, r_vs_sync, r_vs_prev, r_tick;
  logic w_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vs_meta <= 1'b0;
      r_vs_sync <= 1'b0;
      r_vs_prev <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_vs_meta <= vsync;
      r_vs_sync <= r_vs_meta;
      r_vs_prev <= r_vs_sync;
      r_tick    <= r_vs_sync & ~r_vs_prev;
    end
  end

  assign frame_tick = r_tick;
  assign w_adv      = r_tick & enable;

  state_t      r_state [NUM_SPRITES];
  logic [9:0]  r_y     [NUM_SPRITES];
  logic [7:0]  r_cnt   [NUM_SPRITES];
  logic [7:0]  r_hit;
`ifdef FALL_ACCEL_EN
  logic [2:0]  r_vel   [NUM_SPRITES];
  logic [2:0]  r_fcnt  [NUM_SPRITES];
`endif

  logic [10:0]            w_step [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_hit;
  logic [3:0]             w_nhits;
  logic [8:0]             w_hsum;

  // A sprite leaving IDLE takes its first step on the spawn tick itself.
  always_comb begin
    w_nhits = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      w_step[i] = ((r_state[i] == S_IDLE) ? LP_START : {1'b0, r_y[i]})
`ifdef FALL_ACCEL_EN
                  + {8'd0, r_vel[i]};
`else
                  + 11'd1;
`endif
      w_hit[i]  = w_adv && (r_state[i] != S_EXPLODE) && (w_step[i] >= LP_HIT);
      w_nhits   = w_nhits + 4'(w_hit[i]);
    end
    w_hsum = {1'b0, r_hit} + {5'd0, w_nhits};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit <= 8'd0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        r_state[i] <= S_IDLE;
        r_y[i]     <= LP_START[9:0];
        r_cnt[i]   <= 8'd0;
`ifdef FALL_ACCEL_EN
        r_vel[i]   <= 3'd1;
        r_fcnt[i]  <= 3'd0;
`endif
      end
    end else if (w_adv) begin
      r_hit <= w_hsum[8] ? 8'hFF : w_hsum[7:0];
      for (int i = 0; i < NUM_SPRITES; i++) begin
        case (r_state[i])
          S_IDLE, S_FALL: begin
            if (w_hit[i]) begin
              r_y[i]     <= LP_HIT[9:0];
              r_state[i] <= S_EXPLODE;
              r_cnt[i]   <= LP_CNT_INIT;
            end else begin
              r_y[i]     <= w_step[i][9:0];
              r_state[i] <= S_FALL;
            end
`ifdef FALL_ACCEL_EN
            r_fcnt[i] <= r_fcnt[i] + 3'd1;
            if (r_fcnt[i] == 3'd7 && r_vel[i] != 3'd4) r_vel[i] <= r_vel[i] + 3'd1;
`endif
          end
          S_EXPLODE: begin
            if (r_cnt[i] == 8'd0) begin
              r_state[i] <= S_FALL;
              r_y[i]     <= LP_START[9:0];
`ifdef FALL_ACCEL_EN
              r_vel[i]   <= 3'd1;
              r_fcnt[i]  <= 3'd0;
`endif
            end else begin
              r_cnt[i] <= r_cnt[i] - 8'd1;
            end
          end
          default: r_state[i] <= S_IDLE;
        endcase
      end
    end
  end

  assign hit_count = r_hit;

  function automatic logic f_near(input logic [11:0] a, input logic [11:0] b);
    return (a + 12'd2 >= b) && (a <= b + 12'd2);
  endfunction

  logic [NUM_SPRITES-1:0] w_fall_cov, w_exp_cov;
  logic [11:0] w_h, w_v, w_cy;
  assign w_h  = {2'b0, hpos};
  assign w_v  = {2'b0, vpos};
  assign w_cy = 12'(HIT_Y);

  // 12-bit sums keep right-edge and explosion arithmetic from wrapping.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    logic [11:0] w_x, w_y, w_cx, w_d;
    logic [7:0]  w_age;
    assign w_x   = {2'b0, sprite_x[g*10 +: 10]};
    assign w_y   = {2'b0, r_y[g]};
    assign w_cx  = w_x + 12'(SPRITE_W / 2);
    assign w_age = LP_CNT_INIT - r_cnt[g];
    assign w_d   = 12'd5 + {6'd0, w_age[7:2]};
    assign w_fall_cov[g] = (r_state[g] == S_FALL)
                         && (w_h >= w_x) && (w_h < w_x + 12'(SPRITE_W))
                         && (w_v >= w_y) && (w_v < w_y + 12'(SPRITE_H));
    assign w_exp_cov[g]  = (r_state[g] == S_EXPLODE)
                         && ((f_near(w_v, w_cy) && (f_near(w_h + w_d, w_cx) || f_near(w_h, w_cx + w_d)))
                          || (f_near(w_h, w_cx) && (f_near(w_v + w_d, w_cy) || f_near(w_v, w_cy + w_d))));
  end

  logic       w_on, w_exp;
  logic [2:0] w_idx;

  always_comb begin
    w_on  = 1'b0;
    w_exp = 1'b0;
    w_idx = 3'd0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (w_fall_cov[i] || w_exp_cov[i]) begin
        w_on  = 1'b1;
        w_exp = w_exp_cov[i];
        w_idx = 3'(i);
      end
    end
  end

  logic       r_pix_on, r_pix_exp;
  logic [2:0] r_pix_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_on  <= 1'b0;
      r_pix_exp <= 1'b0;
      r_pix_idx <= 3'd0;
    end else begin
      r_pix_on  <= display_on & w_on;
      r_pix_exp <= display_on & w_exp;
      r_pix_idx <= display_on ? w_idx : 3'd0;
    end
  end

  assign pixel_on      = r_pix_on;
  assign pixel_explode = r_pix_exp;
  assign pixel_idx     = r_pix_idx;

endmodule
